// File: rtl/add_serial_pkg.sv
// rtl/add_serial_pkg.sv - shared types and constants for the serial-adder scheduler
package add_serial_pkg;

    localparam int ADD_W       = 8;
    localparam int ADD_LAT_DEF = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/add_serial_sched_if.sv
// rtl/add_serial_sched_if.sv - client request/response bundle of the adder scheduler
interface add_serial_sched_if
    import add_serial_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ADD_W,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    modport master (
        output req, a_in, b_in,
        input  ack, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/add_serial_sched_rr_arbiter.sv
// rtl/add_serial_sched_rr_arbiter.sv - combinational round-robin pick starting after ptr_i
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // The last winner gets the lowest priority: scan ptr+1 .. ptr+NREQ.
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                valid_o = 1'b1;
                idx_o   = IDW'((int'(ptr_i) + k) % NREQ);
                grant_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_serial_sched.sv
// rtl/add_serial_sched.sv - round-robin scheduler sharing one bit-serial adder among NREQ clients
module add_serial_sched
    import add_serial_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = ADD_W,
    parameter int ADD_LAT = ADD_LAT_DEF,
    parameter int IDW     = 2
) (
    input  logic               clk,
    input  logic               rst,
    add_serial_sched_if.slave  cli,
    output logic               busy,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_en,
    input  logic [W-1:0]       add_out
);
    localparam int CW = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;

    generate
        if (ADD_LAT < 2) begin : g_bad_lat
            $error("add_serial_sched: ADD_LAT must be at least 2");
        end
        if (IDW != $clog2(NREQ)) begin : g_bad_idw
            $error("add_serial_sched: IDW must equal clog2(NREQ)");
        end
    endgenerate

    sched_state_t    state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [W-1:0]    add_a_q, add_a_d;
    logic [W-1:0]    add_b_q, add_b_d;
    logic            add_en_q, add_en_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_valid;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (cli.req),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_onehot),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    // Outputs are computed for the state being entered so they are all flop outputs.
    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        rsp_valid_d = 1'b0;
        add_en_d    = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d  = START;
                    add_a_d  = cli.a_in[int'(gnt_idx)*W +: W];
                    add_b_d  = cli.b_in[int'(gnt_idx)*W +: W];
                    rsp_id_d = gnt_idx;
                    rr_ptr_d = gnt_idx;
                    ack_d    = gnt_onehot;
                    add_en_d = 1'b1;
                end
            end
            START: begin
                wait_cnt_d = CW'(ADD_LAT - 1);
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == CW'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_data_d  = add_out;
                rsp_valid_d = 1'b1;
                add_en_d    = 1'b1;
                state_d     = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_en_q    <= add_en_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cli.ack       = ack_q;
    assign cli.rsp_valid = rsp_valid_q;
    assign cli.rsp_id    = rsp_id_q;
    assign cli.rsp_data  = rsp_data_q;
    assign busy          = busy_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign add_en        = add_en_q;
endmodule
